// File: rtl/fifo_ctrl_param_if.sv
// Handshake/status bundle between a FIFO user and fifo_ctrl_param.
// Optional FIFO_CTRL_ERR_EN adds err_clr/overflow/underflow.
interface fifo_ctrl_param_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  write_signal;
  logic                  read_signal;
  logic                  wr_accept;
  logic                  rd_accept;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [ADDR_WIDTH:0]   data_count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
`ifdef FIFO_CTRL_ERR_EN
  logic                  err_clr;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write_signal, read_signal, err_clr,
    input  wr_accept, rd_accept, write_addr, read_addr, data_count,
           full, empty, almost_full, almost_empty, overflow, underflow
  );
  modport slave (
    input  write_signal, read_signal, err_clr,
    output wr_accept, rd_accept, write_addr, read_addr, data_count,
           full, empty, almost_full, almost_empty, overflow, underflow
  );
`else
  modport master (
    output write_signal, read_signal,
    input  wr_accept, rd_accept, write_addr, read_addr, data_count,
           full, empty, almost_full, almost_empty
  );
  modport slave (
    input  write_signal, read_signal,
    output wr_accept, rd_accept, write_addr, read_addr, data_count,
           full, empty, almost_full, almost_empty
  );
`endif
endinterface

// File: rtl/fifo_ctrl_param.sv
// Parametrised single-clock FIFO controller driving an external dual-port RAM; flags registered from next-count.
// FIFO_CTRL_ERR_EN adds sticky overflow/underflow flags with synchronous err_clr.
module fifo_ctrl_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input logic              clk,
  input logic              rst_n,
  fifo_ctrl_param_if.slave fifo
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = AE_LEVEL[ADDR_WIDTH:0];

  if (DATA_WIDTH < 1 || ADDR_WIDTH < 1 || ADDR_WIDTH > 16 || AF_LEVEL < 1 ||
      AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_param
    $error("fifo_ctrl_param: illegal parameter combination");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  wr_acc, rd_acc;

  // Accepts look only at the registered flags; no same-cycle full->write bypass.
  always_comb begin
    wr_acc   = fifo.write_signal & ~full_q;
    rd_acc   = fifo.read_signal & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  assign fifo.wr_accept    = wr_acc;
  assign fifo.rd_accept    = rd_acc;
  assign fifo.write_addr   = wr_ptr_q;
  assign fifo.read_addr    = rd_ptr_q;
  assign fifo.data_count   = count_q;
  assign fifo.full         = full_q;
  assign fifo.empty        = empty_q;
  assign fifo.almost_full  = afull_q;
  assign fifo.almost_empty = aempty_q;

`ifdef FIFO_CTRL_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Set has priority over a coincident clear so no error event is lost.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (fifo.err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (fifo.write_signal & full_q)  ovf_d = 1'b1;
    if (fifo.read_signal  & empty_q) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign fifo.overflow  = ovf_q;
  assign fifo.underflow = unf_q;
`endif
endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Directed bench for fifo_ctrl_param: reference count/pointer model plus a data scoreboard through a modelled RAM.
module tb_fifo_ctrl_param;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_ctrl_param_if #(.ADDR_WIDTH(3)) bus ();
  fifo_ctrl_param_if #(.ADDR_WIDTH(4)) bus4 ();

  fifo_ctrl_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .fifo(bus.slave)
  );
  fifo_ctrl_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .fifo(bus4.slave)
  );

  int         errors = 0;
  int         checks = 0;
  int         exp_cnt, exp_wa, exp_ra;
  logic       exp_ovf, exp_unf;
  logic [7:0] mem [DEPTH];
  logic [7:0] sb [$];
  logic [7:0] wdata = 8'h10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_cnt = 0; exp_wa = 0; exp_ra = 0;
    exp_ovf = 1'b0; exp_unf = 1'b0;
    sb.delete();
  endtask

  task automatic check_state();
    chk("data_count",   32'(bus.data_count),   32'(exp_cnt));
    chk("write_addr",   32'(bus.write_addr),   32'(exp_wa));
    chk("read_addr",    32'(bus.read_addr),    32'(exp_ra));
    chk("full",         32'(bus.full),         32'(exp_cnt == DEPTH));
    chk("empty",        32'(bus.empty),        32'(exp_cnt == 0));
    chk("almost_full",  32'(bus.almost_full),  32'(exp_cnt >= AF));
    chk("almost_empty", 32'(bus.almost_empty), 32'(exp_cnt <= AE));
`ifdef FIFO_CTRL_ERR_EN
    chk("overflow",     32'(bus.overflow),     32'(exp_ovf));
    chk("underflow",    32'(bus.underflow),    32'(exp_unf));
`endif
  endtask

  // One clock of stimulus: drive at negedge, check accepts/RAM data before the edge, state after it.
  task automatic step(input logic w, input logic r);
    logic       wacc, racc, was_full, was_empty, clr;
    logic [7:0] exp_d;
    @(negedge clk);
    bus.write_signal = w;
    bus.read_signal  = r;
    #1;
    was_full  = (exp_cnt == DEPTH);
    was_empty = (exp_cnt == 0);
    wacc = w && !was_full;
    racc = r && !was_empty;
    chk("wr_accept",    32'(bus.wr_accept),  32'(wacc));
    chk("rd_accept",    32'(bus.rd_accept),  32'(racc));
    chk("pre_wr_addr",  32'(bus.write_addr), 32'(exp_wa));
    chk("pre_rd_addr",  32'(bus.read_addr),  32'(exp_ra));
    if (racc) begin
      exp_d = sb.pop_front();
      chk("rd_data", 32'(mem[bus.read_addr]), 32'(exp_d));
    end
    if (wacc) begin
      mem[bus.write_addr] = wdata;
      sb.push_back(wdata);
      wdata = wdata + 8'd1;
    end
`ifdef FIFO_CTRL_ERR_EN
    clr = bus.err_clr;
`else
    clr = 1'b0;
`endif
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + int'(wacc) - int'(racc);
    exp_wa  = (exp_wa + int'(wacc)) % DEPTH;
    exp_ra  = (exp_ra + int'(racc)) % DEPTH;
    if (w && was_full) exp_ovf = 1'b1;
    else if (clr)      exp_ovf = 1'b0;
    if (r && was_empty) exp_unf = 1'b1;
    else if (clr)       exp_unf = 1'b0;
    check_state();
  endtask

  task automatic set_clr(input logic v);
`ifdef FIFO_CTRL_ERR_EN
    bus.err_clr = v;
`else
    if (v) wdata = wdata;
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    bus.write_signal  = 1'b0;
    bus.read_signal   = 1'b0;
    bus4.write_signal = 1'b0;
    bus4.read_signal  = 1'b0;
`ifdef FIFO_CTRL_ERR_EN
    bus.err_clr  = 1'b0;
    bus4.err_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Fill, refused write on full, sticky overflow with set-wins-over-clear.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    set_clr(1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    set_clr(1'b0);

    // Drain, refused read on empty, underflow clear.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    set_clr(1'b1);
    step(1'b0, 1'b0);
    set_clr(1'b0);

    // Simultaneous read+write at count 4, 8 and 0.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);

    // Wrap with steady occupancy of 3.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);

    // Async reset mid-burst at count 5; outputs must clear before the next edge.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    @(negedge clk);
    bus.write_signal = 1'b1;
    bus.read_signal  = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state();
    chk("rst_wr_accept", 32'(bus.wr_accept), 32'(1));
    chk("rst_rd_accept", 32'(bus.rd_accept), 32'(0));
    bus.write_signal = 1'b0;
    bus.read_signal  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);

    // 16-deep variant fills to 16.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus4.write_signal = 1'b1;
      @(posedge clk);
      #1;
      chk("d4_count", 32'(bus4.data_count), 32'(i + 1));
    end
    chk("d4_full",  32'(bus4.full),  32'(1));
    chk("d4_empty", 32'(bus4.empty), 32'(0));
    @(negedge clk);
    #1;
    chk("d4_wr_refused", 32'(bus4.wr_accept), 32'(0));
    bus4.write_signal = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
